// File: rtl/dm_pkg.sv
// Shared types, sizes and the address-legality rule for the data-memory responder.
package dm_pkg;

   localparam int DM_ADDR_WIDTH = 10;
   localparam int DM_WORDS      = 1 << DM_ADDR_WIDTH;
   localparam int BYTE_LANES    = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } dm_state_e;

   // A request is rejected when it is not word aligned or falls outside the word array.
   function automatic logic addr_error(input logic [31:0] addr, input int aw);
      return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
   endfunction

endpackage

// File: rtl/dm_ram.sv
// Word array with one synchronous byte-enabled port; write-first, so a write returns the merged word.
module dm_ram
   import dm_pkg::*;
#(
   parameter int WORDS = DM_WORDS,
   parameter int AW    = $clog2(WORDS)
) (
   input  logic                    clk,
   input  logic                    en_i,
   input  logic                    we_i,
   input  logic [AW-1:0]           addr_i,
   input  logic [31:0]             wdata_i,
   input  logic [BYTE_LANES-1:0]   be_i,
   output logic [31:0]             rdata_o
);

   logic [31:0] mem [WORDS] = '{default: '0};

   // Output register only updates on an access, so it holds between requests.
   always_ff @(posedge clk) begin
      if (en_i) begin
         for (int i = 0; i < BYTE_LANES; i++) begin
            if (we_i && be_i[i]) begin
               mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
               rdata_o[8*i +: 8]     <= wdata_i[8*i +: 8];
            end else begin
               rdata_o[8*i +: 8]     <= mem[addr_i][8*i +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/dm_responder.sv
// Load/store slave for the MIPS core: one request at a time, WAIT_CYCLES wait states,
// then a single-cycle ack carrying read data or an error flag.
module dm_responder
   import dm_pkg::*;
#(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req,
   input  logic                  we,
   input  logic [31:0]           addr,
   input  logic [31:0]           wdata,
   input  logic [BYTE_LANES-1:0] be,
   output logic                  busy,
   output logic                  ack,
   output logic [31:0]           rdata,
   output logic                  err
);

   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   dm_state_e             state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  we_q;
   logic [31:0]           addr_q;
   logic [31:0]           wdata_q;
   logic [BYTE_LANES-1:0] be_q;
   logic                  busy_q, ack_q, err_q;
   logic [31:0]           rdata_q;

   logic                  accept;
   logic                  req_err;
   logic                  ram_en, ram_we;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [31:0]           ram_wdata, ram_rdata;
   logic [BYTE_LANES-1:0] ram_be;

   assign accept  = (state_q == IDLE) && req;
   assign req_err = addr_error(addr_q, ADDR_WIDTH);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               if (WAIT_CYCLES > 0) begin
                  state_d = WAIT;
                  cnt_d   = CW'(WAIT_CYCLES - 1);
               end else begin
                  state_d = RESP;
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) state_d = RESP;
            else             cnt_d   = cnt_q - CW'(1);
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The array access happens on the edge entering RESP; with no wait states that
   // is the acceptance edge itself, so the port is fed straight from the inputs.
   generate
      if (WAIT_CYCLES == 0) begin : g_direct
         assign ram_en    = accept && !addr_error(addr, ADDR_WIDTH);
         assign ram_we    = we;
         assign ram_addr  = addr[ADDR_WIDTH+1:2];
         assign ram_wdata = wdata;
         assign ram_be    = be;
      end else begin : g_latched
         assign ram_en    = (state_q == WAIT) && (cnt_q == '0) && !req_err;
         assign ram_we    = we_q;
         assign ram_addr  = addr_q[ADDR_WIDTH+1:2];
         assign ram_wdata = wdata_q;
         assign ram_be    = be_q;
      end
   endgenerate

   dm_ram #(
      .WORDS (1 << ADDR_WIDTH)
   ) u_ram (
      .clk     (clk),
      .en_i    (ram_en),
      .we_i    (ram_we),
      .addr_i  (ram_addr),
      .wdata_i (ram_wdata),
      .be_i    (ram_be),
      .rdata_o (ram_rdata)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         busy_q  <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= (state_d != IDLE);
         // Response outputs are published on the edge leaving RESP.
         ack_q   <= (state_q == RESP);
         err_q   <= (state_q == RESP) && req_err;
         if (state_q == RESP) begin
            rdata_q <= req_err ? 32'd0 : ram_rdata;
         end
         if (accept) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            be_q    <= be;
         end
      end
   end

   assign busy  = busy_q;
   assign ack   = ack_q;
   assign err   = err_q;
   assign rdata = rdata_q;

endmodule
